current_source_array: RTL and testbench
=======================================

CURRENT_SOURCE_ARRAY -- requirements
Module: current_source_array

Interface
REQ-001 SHALL have parameter N_THERM, default 17, number of thermometer unit outputs.
REQ-002 SHALL have parameter N_BIN, default 6, number of binary-weighted outputs.
REQ-003 SHALL have parameter IREF_NOM, default 500e-6, nominal reference current (A).
REQ-004 SHALL have parameter UNIT_DIV, default 2.5, ratio iref/unit current.
REQ-005 SHALL have parameter SETTLE_CYC, default 8, consecutive in-range cycles required before power-up.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports iref_500ua, vddana_1p8, vddana_0p8, vssana  input  real  reference current and supplies.
REQ-009 SHALL have port pdb  input  1  power-down negate; 0 forces OFF.
REQ-010 SHALL have port therm_code  input  $clog2(N_THERM+1)  requested count of enabled thermometer units.
REQ-011 SHALL have port bin_code  input  N_BIN  requested binary word.
REQ-012 SHALL have ports code_valid input 1 and code_ready output 1  code handshake.
REQ-013 SHALL have port atb_ena  input  2  analog test bus select.
REQ-014 SHALL have ports iout_therm[N_THERM], iout_bin[N_BIN], iout_bin_red  output  real  unit currents.
REQ-015 SHALL have ports atb1, atb0  output  real  analog test bus.
REQ-016 SHALL have ports state_active, fault  output  1  status.

Function
REQ-017 SHALL implement FSM OFF, CHECK, RAMP, ACTIVE, FAULT.
REQ-018 In-range: iref within IREF_NOM +/-10%; vddana_1p8 within 1.8 V +/-5%; vddana_0p8 within 0.8 V +/-5%; vssana within +/-0.05 V; sampled each clk.
REQ-019 OFF -> CHECK when pdb=1; CHECK -> RAMP after SETTLE_CYC consecutive in-range cycles; any out-of-range cycle in CHECK clears the counter.
REQ-020 RAMP: applied thermometer count increments by 1 per cycle from 0 to latched target; -> ACTIVE the cycle it equals target (target 0: RAMP lasts 1 cycle).
REQ-021 Out-of-range in RAMP or ACTIVE -> FAULT next cycle; fault=1; leave FAULT only via pdb=0 (-> OFF).
REQ-022 pdb=0 in any state -> OFF next cycle, with priority over a simultaneous fault.
REQ-023 code_ready=1 only in CHECK and in ACTIVE with applied count equal to target; transfer on code_valid&&code_ready; therm_code > N_THERM SHALL saturate to N_THERM.
REQ-024 In ACTIVE a new target SHALL slew applied count by +/-1 per cycle; code_ready=0 while slewing.
REQ-025 bin_code SHALL apply 1 cycle after transfer, independent of slewing.
REQ-026 In RAMP/ACTIVE: iout_therm[k] = iref_500ua/UNIT_DIV for k < applied count, else 0.0; iout_bin[b] = bit b ? iref_500ua/(UNIT_DIV*2^(N_BIN-b)) : 0.0; iout_bin_red = iout_bin[0] magnitude unconditionally.
REQ-027 In OFF, CHECK, FAULT all current outputs SHALL be `wrealZState.
REQ-028 state_active=1 only in ACTIVE.

Reset
REQ-029 rst=1 SHALL force OFF, applied/target counts 0, bin register 0, settle counter 0, code_ready=0, fault=0, state_active=0, all real outputs `wrealZState; rst overrides pdb and fault.
REQ-030 rst mid-RAMP or mid-slew SHALL abort immediately with no partial currents retained.

Configuration
REQ-031 Macro CSA_ATB_EN defined: atb_ena 00 -> both Z; 01 -> atb1=vddana_1p8, atb0=vssana; 10 -> atb1=vddana_0p8, atb0=iout_therm[N_THERM-1]; 11 -> atb1=iref_500ua, atb0=iout_bin_red; valid in RAMP/ACTIVE, Z otherwise.
REQ-032 Macro CSA_ATB_EN undefined: atb1, atb0 permanently `wrealZState, atb_ena ignored.

Verification
REQ-033 Nominal supplies, iref=500uA, pdb 0->1, therm_code=17 -> ACTIVE after 8 CHECK + 17 RAMP cycles; each iout_therm=200uA.
REQ-034 In ACTIVE at count 17, write therm_code=10 -> count decrements 1/cycle, 7 cycles code_ready=0, then iout_therm[9]=200uA, [10]=0.0.
REQ-035 bin_code=6'b100001 -> 1 cycle later iout_bin[5]=100uA, iout_bin[0]=3.125uA, others 0.0; iout_bin_red=3.125uA.
REQ-036 vddana_1p8 drops to 1.6 V in ACTIVE -> FAULT next cycle, fault=1, outputs Z; persists until pdb=0.
REQ-037 rst pulse mid-RAMP, and iref=560uA during CHECK -> OFF with all Z; CHECK never exits while iref is out of range.
REQ-038 With CSA_ATB_EN, atb_ena=2'b11 in ACTIVE -> atb1=500uA, atb0=3.125uA; without it -> both Z.

Source files
------------

// File: rtl/current_source_array.sv
// Thermometer + binary current-source array behavioural model with supply/reference supervision FSM; optional test bus via CSA_ATB_EN.
// Code transfer on code_valid&&code_ready, bin word applied next cycle, thermometer count slews 1/cycle (code_ready low while slewing).
`ifndef wrealZState
`define wrealZState 1.0e30
`endif

module current_source_array #(
    parameter int  N_THERM    = 17,
    parameter int  N_BIN      = 6,
    parameter real IREF_NOM   = 500e-6,
    parameter real UNIT_DIV   = 2.5,
    parameter int  SETTLE_CYC = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  real                          iref_500ua,
    input  real                          vddana_1p8,
    input  real                          vddana_0p8,
    input  real                          vssana,
    input  logic                         pdb,
    input  logic [$clog2(N_THERM+1)-1:0] therm_code,
    input  logic [N_BIN-1:0]             bin_code,
    input  logic                         code_valid,
    output logic                         code_ready,
    input  logic [1:0]                   atb_ena,
    output real                          iout_therm [N_THERM],
    output real                          iout_bin [N_BIN],
    output real                          iout_bin_red,
    output real                          atb1,
    output real                          atb0,
    output logic                         state_active,
    output logic                         fault
);
    localparam int TW = $clog2(N_THERM + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_RAMP   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    logic [2:0]       r_state;
    logic [TW-1:0]    r_applied;
    logic [TW-1:0]    r_target;
    logic [N_BIN-1:0] r_bin;
    logic [SW-1:0]    r_settle;

    logic          w_in_range;
    logic          w_code_ready;
    logic          w_xfer;
    logic          w_drive;
    logic [TW-1:0] w_therm_sat;
    logic [TW-1:0] w_applied_inc;
    real           w_unit;

    assign w_in_range = (iref_500ua >= IREF_NOM * 0.9) && (iref_500ua <= IREF_NOM * 1.1)
                     && (vddana_1p8 >= 1.71) && (vddana_1p8 <= 1.89)
                     && (vddana_0p8 >= 0.76) && (vddana_0p8 <= 0.84)
                     && (vssana >= -0.05) && (vssana <= 0.05);

    assign w_code_ready  = (r_state == S_CHECK) || ((r_state == S_ACTIVE) && (r_applied == r_target));
    assign w_xfer        = code_valid && w_code_ready;
    assign w_therm_sat   = (therm_code > TW'(N_THERM)) ? TW'(N_THERM) : therm_code;
    assign w_applied_inc = r_applied + TW'(1);
    assign w_drive       = (r_state == S_RAMP) || (r_state == S_ACTIVE);
    assign w_unit        = iref_500ua / UNIT_DIV;

    assign code_ready   = w_code_ready;
    assign state_active = (r_state == S_ACTIVE);
    assign fault        = (r_state == S_FAULT);

    // Power-down shares the reset path so no partial ramp/slew state survives either.
    always_ff @(posedge clk) begin
        if (rst || !pdb) begin
            r_state   <= S_OFF;
            r_applied <= '0;
            r_target  <= '0;
            r_bin     <= '0;
            r_settle  <= '0;
        end else begin
            case (r_state)
                S_OFF: r_state <= S_CHECK;
                S_CHECK: begin
                    if (w_xfer) begin
                        r_target <= w_therm_sat;
                        r_bin    <= bin_code;
                    end
                    if (!w_in_range) begin
                        r_settle <= '0;
                    end else if (r_settle == SW'(SETTLE_CYC - 1)) begin
                        r_settle <= '0;
                        r_state  <= S_RAMP;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                S_RAMP: begin
                    if (!w_in_range) begin
                        r_state   <= S_FAULT;
                        r_applied <= '0;
                    end else if (r_applied == r_target) begin
                        r_state <= S_ACTIVE;
                    end else begin
                        r_applied <= w_applied_inc;
                        if (w_applied_inc == r_target) begin
                            r_state <= S_ACTIVE;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (!w_in_range) begin
                        r_state   <= S_FAULT;
                        r_applied <= '0;
                    end else begin
                        if (r_applied < r_target) begin
                            r_applied <= w_applied_inc;
                        end else if (r_applied > r_target) begin
                            r_applied <= r_applied - TW'(1);
                        end
                        // Transfer only possible when settled, so it never races the slew step.
                        if (w_xfer) begin
                            r_target <= w_therm_sat;
                            r_bin    <= bin_code;
                        end
                    end
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_OFF;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < N_THERM; k++) begin
            iout_therm[k] = `wrealZState;
        end
        for (int b = 0; b < N_BIN; b++) begin
            iout_bin[b] = `wrealZState;
        end
        iout_bin_red = `wrealZState;
        if (w_drive) begin
            for (int k = 0; k < N_THERM; k++) begin
                iout_therm[k] = (k < int'(r_applied)) ? w_unit : 0.0;
            end
            for (int b = 0; b < N_BIN; b++) begin
                iout_bin[b] = r_bin[b] ? (w_unit / real'(1 << (N_BIN - b))) : 0.0;
            end
            iout_bin_red = w_unit / real'(1 << N_BIN);
        end
    end

`ifdef CSA_ATB_EN
    always_comb begin
        atb1 = `wrealZState;
        atb0 = `wrealZState;
        if (w_drive) begin
            case (atb_ena)
                2'b01: begin
                    atb1 = vddana_1p8;
                    atb0 = vssana;
                end
                2'b10: begin
                    atb1 = vddana_0p8;
                    atb0 = iout_therm[N_THERM-1];
                end
                2'b11: begin
                    atb1 = iref_500ua;
                    atb0 = iout_bin_red;
                end
                default: ;
            endcase
        end
    end
`else
    logic w_unused_atb;
    assign w_unused_atb = ^atb_ena;
    assign atb1 = `wrealZState;
    assign atb0 = `wrealZState;
`endif

endmodule

// File: tb/tb_current_source_array.sv
// Randomized bench for current_source_array: latency, slew, bin weights, fault, reset abort, supervision, test bus.
`ifndef wrealZState
`define wrealZState 1.0e30
`endif

module tb_current_source_array;
    localparam int NT = 17;
    localparam int NB = 6;
    localparam int SC = 8;
    localparam int TW = 5;
    localparam real TOL = 1e-12;

    logic          clk = 1'b0;
    logic          rst, pdb, code_valid, code_ready, state_active, fault;
    logic [TW-1:0] therm_code;
    logic [NB-1:0] bin_code;
    logic [1:0]    atb_ena;
    real           iref, v18, v08, vss;
    real           iout_therm [NT];
    real           iout_bin [NB];
    real           iout_bin_red, atb1, atb0;

    int checks = 0;
    int errors = 0;
    int m_count = 0;

    current_source_array dut (
        .clk(clk), .rst(rst), .iref_500ua(iref), .vddana_1p8(v18), .vddana_0p8(v08),
        .vssana(vss), .pdb(pdb), .therm_code(therm_code), .bin_code(bin_code),
        .code_valid(code_valid), .code_ready(code_ready), .atb_ena(atb_ena),
        .iout_therm(iout_therm), .iout_bin(iout_bin), .iout_bin_red(iout_bin_red),
        .atb1(atb1), .atb0(atb0), .state_active(state_active), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    function automatic int obs_count();
        int n = 0;
        for (int k = 0; k < NT; k++)
            if (iout_therm[k] != `wrealZState && iout_therm[k] > 0.0) n++;
        return n;
    endfunction

    function automatic bit obs_all_z();
        bit z = (iout_bin_red == `wrealZState);
        for (int k = 0; k < NT; k++) if (iout_therm[k] != `wrealZState) z = 0;
        for (int b = 0; b < NB; b++) if (iout_bin[b] != `wrealZState) z = 0;
        return z;
    endfunction

    // Number of thermometer outputs differing from "first n units at iref/2.5, rest zero".
    function automatic int therm_bad(input int n);
        int bad = 0;
        for (int k = 0; k < NT; k++)
            if (rabs(iout_therm[k] - ((k < n) ? iref / 2.5 : 0.0)) > TOL) bad++;
        return bad;
    endfunction

    function automatic int sat(input int t);
        return (t > NT) ? NT : t;
    endfunction

    task automatic nominal();
        iref = 500e-6; v18 = 1.8; v08 = 0.8; vss = 0.0;
    endtask

    task automatic set_bad(input int which);
        bit hi = 1'($urandom_range(0, 1));
        case (which)
            0: iref = hi ? 560e-6 : 440e-6;
            1: v18  = hi ? 2.0 : 1.6;
            2: v08  = hi ? 0.9 : 0.7;
            default: vss = hi ? 0.1 : -0.1;
        endcase
    endtask

    task automatic bring_up(input int t, input int b);
        int n = 0;
        pdb = 0; code_valid = 0; tick();
        pdb = 1; tick();
        therm_code = TW'(t); bin_code = NB'(b); code_valid = 1; tick();
        code_valid = 0;
        while (!state_active && n < 200) begin tick(); n++; end
        checks++;
        if (!state_active) begin
            errors++;
            $display("FAIL bring_up_timeout: active=%0b required 1", state_active);
        end
        m_count = sat(t);
    endtask

    task automatic test_reset();
        rst = 1; pdb = 1; code_valid = 1; therm_code = 5'd17; bin_code = '1; atb_ena = 2'b11;
        nominal();
        repeat (3) tick();
        checks++; if (state_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %0b want 0", state_active); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %0b want 0", fault); end
        checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", code_ready); end
        checks++; if (obs_all_z() !== 1'b1) begin errors++; $display("FAIL rst_outputs_z: got %0b want 1", obs_all_z()); end
        checks++; if (atb1 != `wrealZState || atb0 != `wrealZState) begin errors++; $display("FAIL rst_atb_z: got %g/%g", atb1, atb0); end
        rst = 0; code_valid = 0; atb_ena = 2'b00; pdb = 0;
        tick();
    endtask

    task automatic test_powerup(input int t, input int b);
        int lat, prev, c, ramp_err, exp_lat;
        pdb = 0; code_valid = 0; tick();
        pdb = 1; tick();
        checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL check_ready: got %0b want 1", code_ready); end
        therm_code = TW'(t); bin_code = NB'(b); code_valid = 1; tick();
        code_valid = 0;
        lat = 2; prev = -1; ramp_err = 0;
        while (!state_active && lat < 200) begin
            if (!obs_all_z()) begin
                c = obs_count();
                if (c != prev + 1) ramp_err++;
                prev = c;
            end
            tick(); lat++;
        end
        exp_lat = 1 + SC + ((sat(t) == 0) ? 1 : sat(t));
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL powerup_latency t=%0d: got %0d want %0d", t, lat, exp_lat); end
        checks++; if (ramp_err != 0) begin errors++; $display("FAIL ramp_sequence t=%0d: got %0d steps off, want 0", t, ramp_err); end
        checks++; if (obs_count() != sat(t)) begin errors++; $display("FAIL active_count t=%0d: got %0d want %0d", t, obs_count(), sat(t)); end
        checks++; if (therm_bad(sat(t)) != 0) begin errors++; $display("FAIL therm_values t=%0d: got %0d wrong want 0", t, therm_bad(sat(t))); end
        checks++; if (code_ready !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL active_status: ready=%0b fault=%0b want 1/0", code_ready, fault); end
        m_count = sat(t);
    endtask

    task automatic test_slew(input int iters);
        int t, b, a, ts, d, sgn, low;
        real w, e;
        for (int it = 0; it < iters; it++) begin
            t = (it == 0) ? 10 : int'($urandom_range(0, 31));
            b = (it == 0) ? 6'b100001 : int'($urandom_range(0, 63));
            a = m_count; ts = sat(t);
            d = (a > ts) ? a - ts : ts - a;
            sgn = (ts > a) ? 1 : -1;
            therm_code = TW'(t); bin_code = NB'(b); code_valid = 1; tick();
            code_valid = 0; low = 0;
            for (int j = 0; j <= d; j++) begin
                checks++;
                if (obs_count() != a + sgn * j) begin errors++; $display("FAIL slew_count %0d->%0d j=%0d: got %0d want %0d", a, ts, j, obs_count(), a + sgn * j); end
                if (code_ready == 1'b0) low++;
                if (j == 0) begin
                    for (int bb = 0; bb < NB; bb++) begin
                        w = iref / 2.5;
                        for (int s = 0; s < NB - bb; s++) w = w / 2.0;
                        e = b[bb] ? w : 0.0;
                        checks++;
                        if (rabs(iout_bin[bb] - e) > TOL) begin errors++; $display("FAIL bin_out b=%0d code=%0h: got %g want %g", bb, b, iout_bin[bb], e); end
                    end
                    checks++;
                    if (rabs(iout_bin_red - 3.125e-6) > TOL) begin errors++; $display("FAIL bin_red: got %g want 3.125e-6", iout_bin_red); end
                end
                if (j < d) tick();
            end
            checks++; if (low != d || code_ready !== 1'b1) begin errors++; $display("FAIL slew_ready_low %0d->%0d: got %0d low cycles want %0d", a, ts, low, d); end
            if (it == 0) begin
                checks++; if (rabs(iout_therm[9] - 200e-6) > TOL || iout_therm[10] != 0.0) begin errors++; $display("FAIL therm_edge_10: got %g/%g want 2e-4/0", iout_therm[9], iout_therm[10]); end
                checks++; if (rabs(iout_bin[5] - 100e-6) > TOL || rabs(iout_bin[0] - 3.125e-6) > TOL) begin errors++; $display("FAIL bin_100001: got %g/%g want 1e-4/3.125e-6", iout_bin[5], iout_bin[0]); end
            end
            m_count = ts;
        end
    endtask

    task automatic test_fault();
        for (int v = 0; v < 4; v++) begin
            bring_up(int'($urandom_range(0, 17)), int'($urandom_range(0, 63)));
            if (v == 0) v18 = 1.6; else set_bad(v);
            tick();
            checks++; if (fault !== 1'b1 || state_active !== 1'b0) begin errors++; $display("FAIL fault_entry v=%0d: fault=%0b active=%0b want 1/0", v, fault, state_active); end
            checks++; if (obs_all_z() !== 1'b1) begin errors++; $display("FAIL fault_outputs_z v=%0d: got %0b want 1", v, obs_all_z()); end
            nominal(); repeat (3) tick();
            checks++; if (fault !== 1'b1 || code_ready !== 1'b0) begin errors++; $display("FAIL fault_persist v=%0d: fault=%0b ready=%0b want 1/0", v, fault, code_ready); end
            pdb = 0; tick();
            checks++; if (fault !== 1'b0 || obs_all_z() !== 1'b1) begin errors++; $display("FAIL fault_exit v=%0d: fault=%0b want 0", v, fault); end
        end
        bring_up(17, 0);
        set_bad(int'($urandom_range(0, 3))); pdb = 0; tick();
        checks++; if (fault !== 1'b0 || state_active !== 1'b0) begin errors++; $display("FAIL pdb_priority: fault=%0b active=%0b want 0/0", fault, state_active); end
        nominal();
    endtask

    task automatic test_rst_mid_ramp();
        int k, lat;
        k = int'($urandom_range(2, 10));
        pdb = 0; tick(); pdb = 1; tick();
        therm_code = 5'd17; bin_code = 6'h3f; code_valid = 1; tick(); code_valid = 0;
        repeat (SC - 1 + k) tick();
        checks++; if (obs_all_z() !== 1'b0 || state_active !== 1'b0) begin errors++; $display("FAIL mid_ramp_precond: z=%0b active=%0b want 0/0", obs_all_z(), state_active); end
        rst = 1; tick();
        checks++; if (obs_all_z() !== 1'b1 || state_active !== 1'b0 || code_ready !== 1'b0) begin errors++; $display("FAIL rst_abort: z=%0b active=%0b ready=%0b want 1/0/0", obs_all_z(), state_active, code_ready); end
        rst = 0; lat = 0;
        while (!state_active && lat < 200) begin tick(); lat++; end
        checks++; if (lat != SC + 2 || obs_count() != 0) begin errors++; $display("FAIL rst_no_retain: latency %0d count %0d want %0d/0", lat, obs_count(), SC + 2); end
    endtask

    task automatic test_check_oor();
        int bad, g, lat;
        pdb = 0; tick();
        pdb = 1; iref = 560e-6; tick();
        bad = 0;
        repeat (30) begin
            tick();
            if (state_active || !obs_all_z() || code_ready !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL check_stuck_oor: got %0d bad cycles want 0", bad); end
        for (int r = 0; r < 3; r++) begin
            nominal();
            g = int'($urandom_range(1, SC - 1));
            repeat (g) tick();
            set_bad(int'($urandom_range(0, 3))); tick();
            nominal(); lat = 0;
            while (!state_active && lat < 200) begin tick(); lat++; end
            checks++; if (lat != SC + 1) begin errors++; $display("FAIL settle_restart g=%0d: got %0d want %0d", g, lat, SC + 1); end
            pdb = 0; tick(); pdb = 1; tick();
        end
    endtask

    task automatic test_atb();
        real e1, e0;
        bring_up(17, 6'b100001);
        for (int a = 0; a < 4; a++) begin
            atb_ena = 2'(a); #1;
            e1 = `wrealZState; e0 = `wrealZState;
`ifdef CSA_ATB_EN
            case (a)
                1: begin e1 = 1.8; e0 = 0.0; end
                2: begin e1 = 0.8; e0 = 200e-6; end
                3: begin e1 = 500e-6; e0 = 3.125e-6; end
                default: ;
            endcase
`endif
            checks++;
            if (rabs(atb1 - e1) > TOL || rabs(atb0 - e0) > TOL) begin errors++; $display("FAIL atb sel=%0d: got %g/%g want %g/%g", a, atb1, atb0, e1, e0); end
        end
        pdb = 0; tick();
        checks++; if (atb1 != `wrealZState || atb0 != `wrealZState) begin errors++; $display("FAIL atb_off_z: got %g/%g", atb1, atb0); end
        atb_ena = 2'b00;
    endtask

    initial begin
        test_reset();
        test_powerup(17, 0);
        test_slew(8);
        test_powerup(0, int'($urandom_range(0, 63)));
        test_powerup(int'($urandom_range(18, 31)), int'($urandom_range(0, 63)));
        test_powerup(int'($urandom_range(1, 16)), int'($urandom_range(0, 63)));
        test_slew(6);
        test_fault();
        test_rst_mid_ramp();
        test_check_oor();
        test_atb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
